// File: rtl/instr_feeder_pkg.sv
// Shared constants, FSM encoding and opcode helper for the instruction feeder.
package instr_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [2:0] MVI            = 3'b001;
  localparam int         HALT_BIT       = 15;
  localparam int         MEM_DEPTH      = 32;
  localparam int         ADDR_W         = $clog2(MEM_DEPTH);
  localparam int         DATA_W         = 16;
  localparam int         TIMEOUT_CYCLES = 15;

  function automatic logic is_mvi(input logic [2:0] opcode);
    return opcode == MVI;
  endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Processor-side and loader-side signals of the feeder; TimeoutErr exists only with DONE_TIMEOUT_EN.
interface instr_feeder_if;
  import instr_feeder_pkg::*;

  logic              Start;
  logic              Done;
  logic              LoadWe;
  logic [ADDR_W-1:0] LoadAddr;
  logic [DATA_W-1:0] LoadData;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Halted;
  logic [15:0]       InstrCount;
`ifdef DONE_TIMEOUT_EN
  logic              TimeoutErr;

  modport master (
    input  Start, Done, LoadWe, LoadAddr, LoadData,
    output DIN, Run, PC, Busy, Halted, InstrCount, TimeoutErr
  );
  modport slave (
    output Start, Done, LoadWe, LoadAddr, LoadData,
    input  DIN, Run, PC, Busy, Halted, InstrCount, TimeoutErr
  );
`else
  modport master (
    input  Start, Done, LoadWe, LoadAddr, LoadData,
    output DIN, Run, PC, Busy, Halted, InstrCount
  );
  modport slave (
    output Start, Done, LoadWe, LoadAddr, LoadData,
    input  DIN, Run, PC, Busy, Halted, InstrCount
  );
`endif

endinterface

// File: rtl/instr_feeder_prog_mem.sv
// 32x16 program store: synchronous write, two combinational read ports (word and its successor).
module prog_mem
  import instr_feeder_pkg::*;
(
  input  logic              Clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // No reset: program contents must survive Resetn.
  always_ff @(posedge Clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/instr_feeder.sv
// Feeds program-memory words to a processor one instruction at a time (IDLE/FETCH/EXEC/HALT).
// Optional Done watchdog with sticky TimeoutErr is enabled by defining DONE_TIMEOUT_EN.
module instr_feeder
  import instr_feeder_pkg::*;
(
  input  logic           Clock,
  input  logic           Resetn,
  instr_feeder_if.master bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       count_q;
  logic [DATA_W-1:0] word_cur;
  logic [DATA_W-1:0] word_nxt;
  logic              cur_mvi;
  logic              mem_we;
`ifdef DONE_TIMEOUT_EN
  logic [3:0]        tmo_q;
  logic              err_q;
`endif

  assign mem_we  = bus.LoadWe && (state_q == ST_IDLE || state_q == ST_HALT);
  assign cur_mvi = is_mvi(word_cur[8:6]);

  prog_mem u_prog_mem (
    .Clock     (Clock),
    .we_i      (mem_we),
    .waddr_i   (bus.LoadAddr),
    .wdata_i   (bus.LoadData),
    .raddr_a_i (pc_q),
    .rdata_a_o (word_cur),
    .raddr_b_i (pc_q + ADDR_W'(1)),
    .rdata_b_o (word_nxt)
  );

  always_comb begin
    bus.DIN = '0;
    bus.Run = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus.DIN = word_cur;
        bus.Run = !word_cur[HALT_BIT];
      end
      ST_EXEC:  bus.DIN = cur_mvi ? word_nxt : word_cur;
      default:  ;
    endcase
  end

  assign bus.PC         = pc_q;
  assign bus.InstrCount = count_q;
  assign bus.Busy       = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign bus.Halted     = (state_q == ST_HALT);
`ifdef DONE_TIMEOUT_EN
  assign bus.TimeoutErr = err_q;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      count_q <= '0;
`ifdef DONE_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (bus.Start) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            count_q <= '0;
`ifdef DONE_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end
        ST_FETCH: begin
          state_q <= word_cur[HALT_BIT] ? ST_HALT : ST_EXEC;
`ifdef DONE_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        ST_EXEC: begin
          if (bus.Done) begin
            state_q <= ST_FETCH;
            pc_q    <= pc_q + (cur_mvi ? ADDR_W'(2) : ADDR_W'(1));
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
          end
`ifdef DONE_TIMEOUT_EN
          // Last EXEC cycle is the 14th after Run, so Halted shows on the 15th.
          else if (tmo_q == 4'(TIMEOUT_CYCLES - 2)) begin
            state_q <= ST_HALT;
            err_q   <= 1'b1;
          end else begin
            tmo_q   <= tmo_q + 4'd1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
